// File: rtl/spirxdata_blk_if.sv
// spirxdata_blk_if: bundles the command, low-level SPI byte engine and
// buffer-memory signals of the SD SPI receive-data block.
//   slave  modport : the receive block itself (inputs i_*, outputs o_*)
//   master modport : the command controller / SPI engine / memory side
// Signal groups:
//   command : i_start, i_lgblksz, i_fifo, o_busy, o_rxvalid, o_status, o_response
//   ll byte : i_ll_busy, o_ll_stb, o_ll_byte, i_ll_stb, i_ll_byte
//   memory  : o_write, o_addr, o_data
interface spirxdata_blk_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic          i_start;
  logic [3:0]    i_lgblksz;
  logic          i_fifo;
  logic          o_busy;
  logic          i_ll_busy;
  logic          o_ll_stb;
  logic [7:0]    o_ll_byte;
  logic          i_ll_stb;
  logic [7:0]    i_ll_byte;
  logic          o_write;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_rxvalid;
  logic [1:0]    o_status;
  logic [7:0]    o_response;

  modport slave (
    input  i_start, i_lgblksz, i_fifo, i_ll_busy, i_ll_stb, i_ll_byte,
    output o_busy, o_ll_stb, o_ll_byte, o_write, o_addr, o_data,
           o_rxvalid, o_status, o_response
  );

  modport master (
    output i_start, i_lgblksz, i_fifo, i_ll_busy, i_ll_stb, i_ll_byte,
    input  o_busy, o_ll_stb, o_ll_byte, o_write, o_addr, o_data,
           o_rxvalid, o_status, o_response
  );
endinterface

// File: rtl/spirxdata_blk.sv
// spirxdata_blk: SD-card SPI data-block receiver. Clocks 0xFF filler bytes
// through the shared byte engine, hunts for the 0xFE start token, packs the
// payload big-endian into DW-bit words written to one buffer half, then
// consumes the trailing CRC16 and reports a status.
// Ports:
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   bus        spirxdata_blk_if.slave (command, byte engine, memory signals)
// Status codes: 0 ok, 1 CRC error, 2 error token, 3 token timeout.
// Optional feature: define SPIRXDATA_CRC_CHECK_EN to compute and compare the
// CRC16-CCITT of the payload; otherwise CRC bytes are discarded and a
// completed block reports status 0.
module spirxdata_blk #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int TIMEOUT = 1023
) (
  input logic           i_clk,
  input logic           i_reset_n,
  spirxdata_blk_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_DATA,
    S_CRC1,
    S_CRC2,
    S_DONE
  } state_t;

  state_t        state, state_nx;

  logic          receiving;
  logic          rx;
  logic          ll_stb;
  logic          outstanding;
  logic [TW-1:0] tcount;
  logic [9:0]    bcount;
  logic [9:0]    blk_last;
  logic [3:0]    lgblksz;
  logic          is_token;
  logic          is_err;
  logic          timeout_hit;
  logic          data_last;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [1:0]    status;
  logic [7:0]    response;

`ifdef SPIRXDATA_CRC_CHECK_EN
  logic [15:0]   crc;
  logic [15:0]   crc_nx;
  logic [7:0]    crc_hi;

  // CRC16-CCITT, poly 0x1021, MSB-first, one byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned k = 0; k < 8; k++) begin
      if (r[15] ^ d[7 - k]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else                  r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb crc_nx = crc16_byte(crc, bus.i_ll_byte);
`endif

  assign receiving   = (state == S_TOKEN) || (state == S_DATA) ||
                       (state == S_CRC1)  || (state == S_CRC2);
  // received bytes outside the receiving states are ignored
  assign rx          = bus.i_ll_stb && receiving;
  assign is_token    = (bus.i_ll_byte == 8'hfe);
  assign is_err      = (bus.i_ll_byte[7:4] == 4'h0) && (bus.i_ll_byte != 8'h00);
  assign timeout_hit = (tcount == TW'(TIMEOUT));
  assign blk_last    = (10'd1 << lgblksz) - 10'd1;
  assign data_last   = (bcount == blk_last);

  // state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.i_start) state_nx = S_TOKEN;
      S_TOKEN: if (rx) begin
                 if (is_token)                   state_nx = S_DATA;
                 else if (is_err || timeout_hit) state_nx = S_DONE;
               end
      S_DATA:  if (rx && data_last) state_nx = S_CRC1;
      S_CRC1:  if (rx) state_nx = S_CRC2;
      S_CRC2:  if (rx) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    bus.o_busy    = receiving;
    bus.o_rxvalid = (state == S_DONE);
    ll_stb        = receiving && !outstanding;
    bus.o_ll_stb  = ll_stb;
    bus.o_ll_byte = '1;
  end

  assign bus.o_write    = write;
  assign bus.o_addr     = addr;
  assign bus.o_data     = data;
  assign bus.o_status   = status;
  assign bus.o_response = response;

  // datapath
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      outstanding <= 1'b0;
      tcount      <= '0;
      bcount      <= '0;
      lgblksz     <= '0;
      write       <= 1'b0;
      addr        <= '0;
      data        <= '0;
      status      <= '0;
      response    <= '0;
`ifdef SPIRXDATA_CRC_CHECK_EN
      crc         <= '0;
      crc_hi      <= '0;
`endif
    end else begin
      write <= 1'b0;
      // word index advances the cycle after each write; the half bit is kept
      if (write) addr[AW-2:0] <= addr[AW-2:0] + 1'b1;

      // one byte outstanding at most: set on acceptance, cleared on reply
      if (!receiving)                    outstanding <= 1'b0;
      else if (rx)                       outstanding <= 1'b0;
      else if (ll_stb && !bus.i_ll_busy) outstanding <= 1'b1;

      unique case (state)
        S_IDLE: if (bus.i_start) begin
          lgblksz  <= bus.i_lgblksz;
          addr     <= {bus.i_fifo, {(AW-1){1'b0}}};
          bcount   <= '0;
          tcount   <= '0;
          status   <= '0;
          response <= '0;
`ifdef SPIRXDATA_CRC_CHECK_EN
          crc      <= '0;
`endif
        end
        S_TOKEN: if (rx && !is_token) begin
          if (is_err) begin
            response <= bus.i_ll_byte;
            status   <= 2'd2;
          end else if (timeout_hit) begin
            status   <= 2'd3;
          end else begin
            tcount   <= tcount + TW'(1);
          end
        end
        S_DATA: if (rx) begin
          data   <= {data[DW-9:0], bus.i_ll_byte};
          bcount <= bcount + 10'd1;
          if (bcount[1:0] == 2'b11) write <= 1'b1;
`ifdef SPIRXDATA_CRC_CHECK_EN
          crc    <= crc_nx;
`endif
        end
        S_CRC1: begin
`ifdef SPIRXDATA_CRC_CHECK_EN
          if (rx) crc_hi <= bus.i_ll_byte;
`endif
        end
        S_CRC2: if (rx) begin
`ifdef SPIRXDATA_CRC_CHECK_EN
          status <= ({crc_hi, bus.i_ll_byte} == crc) ? 2'd0 : 2'd1;
`else
          status <= 2'd0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spirxdata_blk.sv
module tb_spirxdata_blk;

  localparam int DW      = 32;
  localparam int AW      = 8;
  localparam int TIMEOUT = 1023;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;

  spirxdata_blk_if #(.DW(DW), .AW(AW)) bus ();

  spirxdata_blk #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] card_q[$];
  wr_t        exp_wq[$];
  int         rd_idx     = 0;
  int         rsp_wait   = 0;
  int         rsp_delay  = 0;
  int         busy_cfg   = 0;
  int         busy_left  = 0;
  bit         expect_rx  = 0;
  bit         rx_seen    = 0;
  logic [1:0] exp_status = '0;
  logic [7:0] exp_resp   = '0;
  int         exp_consumed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      r = (r[15] ^ d[k]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] card_at(input int i);
    return (i < card_q.size()) ? card_q[i] : 8'hff;
  endfunction

  // Expected outcome of the card's byte stream, derived from the protocol rules.
  task automatic build_expect(input int lg, input bit fifo);
    int          i;
    int          fill;
    int          n;
    logic [15:0] crc;
    logic [15:0] rxcrc;
    logic [31:0] w;
    logic [7:0]  b;
    i = 0; fill = 0;
    exp_wq.delete();
    exp_status = 2'd0;
    exp_resp   = 8'h00;
    forever begin
      b = card_at(i); i++;
      if (b == 8'hfe) break;
      if (b[7:4] == 4'h0 && b != 8'h00) begin
        exp_status = 2'd2; exp_resp = b; exp_consumed = i;
        return;
      end
      fill++;
      if (fill == TIMEOUT + 1) begin
        exp_status = 2'd3; exp_consumed = i;
        return;
      end
    end
    n = 1 << lg; crc = '0; w = '0;
    for (int k = 0; k < n; k++) begin
      b = card_at(i); i++;
      crc = crc16_upd(crc, b);
      w = {w[23:0], b};
      if (k % 4 == 3) exp_wq.push_back(wr_t'{addr: {fifo, 7'(k / 4)}, data: w});
    end
    rxcrc = {card_at(i), card_at(i + 1)};
    i += 2;
`ifdef SPIRXDATA_CRC_CHECK_EN
    exp_status = (rxcrc == crc) ? 2'd0 : 2'd1;
`else
    exp_status = 2'd0;
`endif
    exp_consumed = i;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_block(input int lg, input bit fifo, input int bsy);
    int c;
    rd_idx = 0; busy_cfg = bsy; busy_left = bsy; rx_seen = 0; expect_rx = 1;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_lgblksz = 4'(lg); bus.i_fifo = fifo;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("busy_after_start", bus.o_busy, 1);
    for (c = 0; c < 20000 && !rx_seen; c++) @(negedge clk);
    if (!rx_seen) begin
      check("rxvalid_wait", 0, 1);
      expect_rx = 0;
      exp_wq.delete();
      do_reset();
    end else begin
      repeat (3) @(negedge clk);
      check("status_held", bus.o_status, exp_status);
      check("response_held", bus.o_response, exp_resp);
      check("busy_after_done", bus.o_busy, 0);
    end
  endtask

  // card / byte-engine responder
  initial begin
    bus.i_ll_busy = 1'b0; bus.i_ll_stb = 1'b0; bus.i_ll_byte = 8'h00;
    forever begin
      @(negedge clk);
      bus.i_ll_stb = 1'b0;
      if (rsp_wait > 0) begin
        rsp_wait--;
        if (rsp_wait == 0) begin
          bus.i_ll_byte = card_at(rd_idx);
          rd_idx++;
          bus.i_ll_stb = 1'b1;
        end
      end else if (bus.o_ll_stb) begin
        if (busy_left > 0) begin
          bus.i_ll_busy = 1'b1;
          busy_left--;
        end else begin
          bus.i_ll_busy = 1'b0;
          rsp_wait  = (rsp_delay > 0) ? rsp_delay : 1 + int'($urandom_range(0, 2));
          busy_left = busy_cfg;
        end
      end else begin
        bus.i_ll_busy = 1'($urandom_range(0, 1));
      end
    end
  end

  // compare process
  initial begin
    logic prev_stb;
    wr_t  w;
    prev_stb = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        prev_stb = 1'b0;
        continue;
      end
      if (prev_stb) begin
        if (bus.i_ll_busy) check("ll_stb_hold", bus.o_ll_stb, 1);
        else               check("ll_stb_drop", bus.o_ll_stb, 0);
      end
      prev_stb = bus.o_ll_stb;
      if (bus.o_ll_stb) check("ll_byte", bus.o_ll_byte, 8'hff);
      if (bus.o_write) begin
        if (exp_wq.size() == 0) check("unexpected_write", 1, 0);
        else begin
          w = exp_wq.pop_front();
          check("wr_addr", bus.o_addr, w.addr);
          check("wr_data", bus.o_data, w.data);
        end
      end
      if (bus.o_rxvalid) begin
        if (!expect_rx) check("unexpected_rxvalid", 1, 0);
        else begin
          check("rx_status", bus.o_status, exp_status);
          check("rx_response", bus.o_response, exp_resp);
          check("rx_bytes_consumed", rd_idx, exp_consumed);
          check("rx_busy_low", bus.o_busy, 0);
          check("writes_outstanding", exp_wq.size(), 0);
          expect_rx = 0;
          rx_seen   = 1;
        end
      end
    end
  end

  initial begin
    logic [15:0] crc;
    logic [7:0]  b;
    int          lg, nf, kind, found;
    bit          fifo;

    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_lgblksz = 4'd4; bus.i_fifo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_ll_stb", bus.o_ll_stb, 0);
    check("rst_write", bus.o_write, 0);
    check("rst_rxvalid", bus.o_rxvalid, 0);
    check("rst_status", bus.o_status, 0);
    check("rst_response", bus.o_response, 0);
    check("rst_addr", bus.o_addr, 0);
    check("rst_data", bus.o_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // pin the CRC model to the standard check value
    crc = '0;
    for (int i = 0; i < 9; i++) crc = crc16_upd(crc, 8'(8'h31 + i));
    check("model_crc_123456789", crc, 16'h31c3);

    // FF FF FE, 00..0F, correct CRC
    card_q.delete();
    card_q.push_back(8'hff); card_q.push_back(8'hff); card_q.push_back(8'hfe);
    crc = '0;
    for (int i = 0; i < 16; i++) begin
      card_q.push_back(8'(i));
      crc = crc16_upd(crc, 8'(i));
    end
    card_q.push_back(crc[15:8]); card_q.push_back(crc[7:0]);
    build_expect(4, 1'b0);
    check("model_t1_nwords", exp_wq.size(), 4);
    check("model_t1_w0", exp_wq[0].data, 32'h00010203);
    check("model_t1_w3", exp_wq[3].data, 32'h0c0d0e0f);
    check("model_t1_a3", exp_wq[3].addr, 8'h03);
    check("model_t1_status", exp_status, 0);
    run_block(4, 1'b0, 0);

    // 512 x FF into upper half, CRC 7F A1 then 7F A0
    for (int t = 0; t < 2; t++) begin
      card_q.delete();
      card_q.push_back(8'hfe);
      for (int i = 0; i < 512; i++) card_q.push_back(8'hff);
      card_q.push_back(8'h7f);
      card_q.push_back((t == 0) ? 8'ha1 : 8'ha0);
      build_expect(9, 1'b1);
      check("model_512_nwords", exp_wq.size(), 128);
      run_block(9, 1'b1, t);
    end

    // error token
    card_q.delete();
    card_q.push_back(8'hff); card_q.push_back(8'hff); card_q.push_back(8'hff);
    card_q.push_back(8'h09);
    build_expect(4, 1'b0);
    check("model_errtok_consumed", exp_consumed, 4);
    run_block(4, 1'b0, 1);

    // timeout: card only returns FF
    card_q.delete();
    build_expect(5, 1'b0);
    check("model_timeout_consumed", exp_consumed, TIMEOUT + 1);
    check("model_timeout_status", exp_status, 3);
    run_block(5, 1'b0, 0);

    // randomized blocks
    for (int r = 0; r < 8; r++) begin
      card_q.delete();
      lg   = 4 + int'($urandom_range(0, 5));
      fifo = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      nf   = int'($urandom_range(0, 4));
      for (int i = 0; i < nf; i++) begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hfe || (b[7:4] == 4'h0 && b != 8'h00));
        card_q.push_back(b);
      end
      if (kind == 0) begin
        card_q.push_back(8'($urandom_range(1, 15)));
      end else begin
        card_q.push_back(8'hfe);
        crc = '0;
        for (int i = 0; i < (1 << lg); i++) begin
          b = 8'($urandom_range(0, 255));
          card_q.push_back(b);
          crc = crc16_upd(crc, b);
        end
        if (kind == 1) crc = crc ^ 16'(1 << $urandom_range(0, 15));
        card_q.push_back(crc[15:8]); card_q.push_back(crc[7:0]);
      end
      build_expect(lg, fifo);
      run_block(lg, fifo, int'($urandom_range(0, 3)));
    end

    // reset mid-transfer with a byte outstanding and a slow, busy engine
    card_q.delete();
    card_q.push_back(8'hfe);
    for (int i = 0; i < 16; i++) card_q.push_back(8'(8'h40 + i));
    exp_wq.delete();
    exp_wq.push_back(wr_t'{addr: 8'h80, data: 32'h40414243});
    expect_rx = 0; rx_seen = 0; rd_idx = 0;
    rsp_delay = 4; busy_cfg = 5; busy_left = 5;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_lgblksz = 4'd9; bus.i_fifo = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      @(posedge clk); #2;
      if (rd_idx == 7 && rsp_wait > 0) found = 1;
    end
    check("reset_point_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_ll_stb", bus.o_ll_stb, 0);
    check("midrst_addr", bus.o_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("late_byte_delivered", rd_idx, 8);
    check("late_busy", bus.o_busy, 0);
    check("late_data", bus.o_data, 0);
    check("late_addr", bus.o_addr, 0);
    check("late_writes_left", exp_wq.size(), 0);
    rsp_delay = 0; busy_cfg = 0; busy_left = 0;

    // normal operation resumes after the reset
    card_q.delete();
    card_q.push_back(8'hfe);
    crc = '0;
    for (int i = 0; i < 16; i++) begin
      card_q.push_back(8'(8'ha0 + i));
      crc = crc16_upd(crc, 8'(8'ha0 + i));
    end
    card_q.push_back(crc[15:8]); card_q.push_back(crc[7:0]);
    build_expect(4, 1'b1);
    run_block(4, 1'b1, 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
